pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
Parametrised, handshaked pipeline stage register. It generalises the ID/EX-style latch with stall/clear, replacing the global stall with per-stage valid/ready flow control. A 2-entry skid buffer keeps in_ready registered, so backpressure does not ripple combinationally through the pipe. Adds flush (bubble injection), a hold indicator and a saturating stall-cycle counter. Any stage boundary (IF/ID, ID/EX, EX/MEM) instantiates it with its own payload widths.

Parameters:
DATA_W, 32, width of the operand/data payload (rs1_val, rs2_val, immediate, PC, and so on, concatenated by the instantiator)
CTRL_W, 11, width of the control payload (datapath bits); forced to zero whenever the slot is empty
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock; all state updates on the rising edge
clr  in  1  reset: synchronous, active-high; highest priority
in_valid  in  1  upstream presents an instruction
in_ready  out  1  stage can accept; registered
in_data  in  DATA_W  incoming data payload
in_ctrl  in  CTRL_W  incoming control payload
flush  in  1  synchronous kill of all held and incoming entries
out_valid  out  1  stage presents an instruction downstream
out_ready  in  1  downstream accepts
out_data  out  DATA_W  main-slot data
out_ctrl  out  CTRL_W  main-slot control; 0 when out_valid=0
out_bubble  out  1  registered: previous cycle was a held (backpressured) cycle
stall_cnt  out  CNT_W  saturating count of backpressured cycles

Behaviour:
- Storage: main slot (valid, data, ctrl) drives the outputs. Skid slot (valid, data, ctrl) is internal. State is encoded as EMPTY (no valid entries), ONE (main valid) or TWO (main and skid valid).
- acc = in_valid & in_ready. take = out_valid & out_ready.
- in_ready = (state != TWO), taken from a register.
- out_valid = main valid. out_ctrl = out_valid ? main_ctrl : 0. out_data holds its last value when empty.
- Priority, highest first: clr > flush > normal transfer.
- clr: both valid bits, data, ctrl, out_bubble and stall_cnt go to 0; state goes to EMPTY; in_ready is 1 in the cycle after reset.
- flush (clr=0): both valid bits and both ctrl fields are cleared; state goes to EMPTY. An entry accepted in the same cycle (acc=1) is discarded. stall_cnt is retained. out_bubble goes to 0.
- EMPTY:
  - acc → ONE; main loads in_*.
  - otherwise stay in EMPTY.
- ONE:
  - acc & take → ONE; main loads in_*.
  - acc & !take → TWO; skid loads in_*.
  - !acc & take → EMPTY.
  - neither → hold.
- TWO:
  - take → ONE; main loads the skid contents.
  - otherwise hold. in_ready=0, so acc is impossible.
- Latency: one cycle from accept to out_valid when the stage is empty. Throughput is one per cycle while out_ready=1.
- Ordering is strictly FIFO: a skid entry is always delivered before any later input.
- out_bubble is registered: out_bubble <= out_valid & !out_ready (forced 0 on clr or flush).
- stall_cnt increments by 1 on each cycle with out_valid & !out_ready and no clr/flush. It saturates at 2^CNT_W-1 and does not wrap. Only clr clears it.
- Payload bits are never modified in transit; the only transformation is zeroing ctrl on empty/flush.
- Reset mid-operation: all entries are lost. No partial transfer is presented after clr.

Test Plan:
- Reset → clr=1 for 2 cycles, then release → out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0, out_bubble=0.
- Streaming → with out_ready=1, send data 0x1,0x2,0x3 on consecutive cycles, ctrl=0x7FF → outputs appear one cycle later in order, with no gaps and in_ready constantly 1.
- Skid fill → send A=0xA then B=0xB with out_ready=0 → state TWO and in_ready=0 in the next cycle, out_data=0xA held, stall_cnt counts each held cycle. Raise out_ready → A then B are delivered, and in_ready returns to 1 one cycle after A leaves.
- Flush → in state TWO, assert flush while in_valid=1 with C=0xC → next cycle out_valid=0, out_ctrl=0, in_ready=1, and C is never output. stall_cnt is unchanged.
- Saturation → CNT_W=3, hold out_valid=1 with out_ready=0 for 10 cycles → stall_cnt stops at 7, and out_bubble=1 from the second held cycle onward.
- clr versus flush → assert clr and flush together in state ONE → full reset: stall_cnt=0 and out_valid=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a 2-entry skid buffer, a registered
// in_ready, flush, a hold indicator and a saturating stall counter.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_bubble,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t              state;
    logic                in_ready_p0;
    logic                main_vld_p0;
    logic [DATA_W-1:0]   main_data_p0;
    logic [CTRL_W-1:0]   main_ctrl_p0;
    logic                skid_vld_p0;
    logic [DATA_W-1:0]   skid_data_p0;
    logic [CTRL_W-1:0]   skid_ctrl_p0;
    logic                bubble_p0;
    logic [CNT_W-1:0]    stall_cnt_p0;

    logic acc;
    logic take;
    logic held;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign acc  = in_valid & in_ready_p0;
    assign take = main_vld_p0 & out_ready;
    assign held = main_vld_p0 & ~out_ready;

    // Stage register: main slot feeds the outputs, skid slot absorbs one extra entry
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= EMPTY;
            in_ready_p0  <= 1'b1;
            main_vld_p0  <= 1'b0;
            main_data_p0 <= '0;
            main_ctrl_p0 <= '0;
            skid_vld_p0  <= 1'b0;
            skid_data_p0 <= '0;
            skid_ctrl_p0 <= '0;
            bubble_p0    <= 1'b0;
            stall_cnt_p0 <= '0;
        end else if (flush) begin
            // Data is kept so out_data still holds its last value; entries are gone
            state        <= EMPTY;
            in_ready_p0  <= 1'b1;
            main_vld_p0  <= 1'b0;
            main_ctrl_p0 <= '0;
            skid_vld_p0  <= 1'b0;
            skid_ctrl_p0 <= '0;
            bubble_p0    <= 1'b0;
        end else begin
            bubble_p0 <= held;
            if (held) begin
                stall_cnt_p0 <= sat_inc(stall_cnt_p0);
            end
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_vld_p0  <= 1'b1;
                        main_data_p0 <= in_data;
                        main_ctrl_p0 <= in_ctrl;
                        state        <= ONE;
                    end
                end
                ONE: begin
                    if (acc && take) begin
                        main_data_p0 <= in_data;
                        main_ctrl_p0 <= in_ctrl;
                    end else if (acc) begin
                        skid_vld_p0  <= 1'b1;
                        skid_data_p0 <= in_data;
                        skid_ctrl_p0 <= in_ctrl;
                        in_ready_p0  <= 1'b0;
                        state        <= TWO;
                    end else if (take) begin
                        main_vld_p0  <= 1'b0;
                        main_ctrl_p0 <= '0;
                        state        <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain case can occur
                    if (take) begin
                        main_data_p0 <= skid_data_p0;
                        main_ctrl_p0 <= skid_ctrl_p0;
                        skid_vld_p0  <= 1'b0;
                        skid_ctrl_p0 <= '0;
                        in_ready_p0  <= 1'b1;
                        state        <= ONE;
                    end
                end
                default: begin
                    main_vld_p0 <= 1'b0;
                    skid_vld_p0 <= 1'b0;
                    in_ready_p0 <= 1'b1;
                    state       <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_p0;
    assign out_valid  = main_vld_p0;
    assign out_data   = main_data_p0;
    assign out_ctrl   = main_vld_p0 ? main_ctrl_p0 : '0;
    assign out_bubble = bubble_p0;
    assign stall_cnt  = stall_cnt_p0;

endmodule
